// File: rtl/vga_timing_pkg.sv
// Shared timing types and defaults for the VGA sync generator.
// Phase encoding and a reference phase decoder for one display axis.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic phase_t phase_of(
    input int unsigned cnt,
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync
  );
    if (cnt < act)
      return PH_ACTIVE;
    else if (cnt < act + fp)
      return PH_FRONT;
    else if (cnt < act + fp + sync)
      return PH_SYNC;
    else
      return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the sync generator and the display buffer.
// master drives sync/flags/counters, slave drives the run enable.
interface vga_sync_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
);
  logic          en;
  logic          HS;
  logic          VS;
  logic          DF_VGA;
  logic          DF_UART;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  modport master (
    input  en,
    output HS, VS, DF_VGA, DF_UART,
    output h_cnt, v_cnt
  );

  modport slave (
    output en,
    input  HS, VS, DF_VGA, DF_UART,
    input  h_cnt, v_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: position counter plus its four-phase FSM.
// phase is the phase the axis holds after the coming edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int unsigned ACTIVE = 640,
  parameter  int unsigned FP     = 16,
  parameter  int unsigned SYNC   = 96,
  parameter  int unsigned BP     = 48,
  localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int unsigned W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output phase_t       phase,
  output logic         wrap
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] E_ACT  = W'(ACTIVE - 1);
  localparam logic [W-1:0] E_FP   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] E_SYNC = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] cnt_q, cnt_d;
  phase_t       phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    wrap    = step && (cnt_q == LAST);
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      unique case (phase_q)
        PH_ACTIVE: if (cnt_q == E_ACT)  phase_d = PH_FRONT;
        PH_FRONT:  if (cnt_q == E_FP)   phase_d = PH_SYNC;
        PH_SYNC:   if (cnt_q == E_SYNC) phase_d = PH_BACK;
        PH_BACK:   if (cnt_q == LAST)   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign cnt   = cnt_q;
  assign phase = phase_d;

  // FSM state must always agree with a direct decode of the count
  a_phase_consistent: assert property (
    @(posedge clk) disable iff (rst)
    phase_q == phase_of(32'(cnt_q), ACTIVE, FP, SYNC)
  );

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, H/V axes and
// registered HS/VS/DF_VGA plus the end-of-frame DF_UART pulse.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic       clk,
  input logic       rst,
  vga_sync_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

  logic [DW-1:0] div_q, div_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          df_vga_q, df_vga_d;
  logic          df_uart_q, df_uart_d;
  logic          tick;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  phase_t        h_phase, v_phase;
  logic          h_wrap, v_wrap;

  assign tick = bus.en && (div_q == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk   (clk),
    .rst   (rst),
    .step  (tick),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk   (clk),
    .rst   (rst),
    .step  (h_wrap),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Flags track the axes' next phase so they line up with the counters
  always_comb begin
    div_d     = div_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    df_vga_d  = df_vga_q;
    df_uart_d = 1'b0;
    if (bus.en) begin
      div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      hs_d      = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_d      = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      df_vga_d  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      df_uart_d = h_wrap && (v_cnt == V_LAST_ACT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      df_vga_q  <= 1'b0;
      df_uart_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      df_vga_q  <= df_vga_d;
      df_uart_q <= df_uart_d;
    end
  end

  assign bus.HS      = hs_q;
  assign bus.VS      = vs_q;
  assign bus.DF_VGA  = df_vga_q;
  assign bus.DF_UART = df_uart_q;
  assign bus.h_cnt   = h_cnt;
  assign bus.v_cnt   = v_cnt;

  a_v_wrap_at_h_wrap: assert property (
    @(posedge clk) disable iff (rst)
    v_wrap |-> (h_cnt == H_LAST)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three timing configs checked each
// clk against an arithmetic model of position vs. enabled clks.
module tb_vga_sync_gen;

  typedef struct packed {
    int ht_unused;
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        dv;
    logic        du;
    logic [15:0] h;
    logic [15:0] v;
  } obs_t;

  localparam cfg_t CA = '{ht_unused: 0, d: 4,
    ha: 640, hf: 16, hs: 96, hb: 48,
    va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
  localparam cfg_t CB = '{ht_unused: 0, d: 2,
    ha: 20, hf: 3, hs: 5, hb: 4,
    va: 6, vf: 2, vs: 2, vb: 3, pol: 1'b0};
  localparam cfg_t CC = '{ht_unused: 0, d: 1,
    ha: 8, hf: 1, hs: 2, hb: 1,
    va: 4, vf: 1, vs: 1, vb: 1, pol: 1'b1};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_if #(.HW(10), .VW(10)) ba ();
  vga_sync_if #(.HW(5),  .VW(4))  bb ();
  vga_sync_if #(.HW(4),  .VW(3))  bc ();

  vga_sync_gen #(
    .CLK_DIV(CA.d), .H_ACTIVE(CA.ha), .H_FP(CA.hf),
    .H_SYNC(CA.hs), .H_BP(CA.hb), .V_ACTIVE(CA.va),
    .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
    .SYNC_POL(CA.pol)
  ) u_a (.clk(clk), .rst(rst_a), .bus(ba));

  vga_sync_gen #(
    .CLK_DIV(CB.d), .H_ACTIVE(CB.ha), .H_FP(CB.hf),
    .H_SYNC(CB.hs), .H_BP(CB.hb), .V_ACTIVE(CB.va),
    .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
    .SYNC_POL(CB.pol)
  ) u_b (.clk(clk), .rst(rst_b), .bus(bb));

  vga_sync_gen #(
    .CLK_DIV(CC.d), .H_ACTIVE(CC.ha), .H_FP(CC.hf),
    .H_SYNC(CC.hs), .H_BP(CC.hb), .V_ACTIVE(CC.va),
    .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb),
    .SYNC_POL(CC.pol)
  ) u_c (.clk(clk), .rst(rst_c), .bus(bc));

  obs_t oa, ob, oc;
  assign oa = {ba.HS, ba.VS, ba.DF_VGA, ba.DF_UART,
               16'(ba.h_cnt), 16'(ba.v_cnt)};
  assign ob = {bb.HS, bb.VS, bb.DF_VGA, bb.DF_UART,
               16'(bb.h_cnt), 16'(bb.v_cnt)};
  assign oc = {bc.HS, bc.VS, bc.DF_VGA, bc.DF_UART,
               16'(bc.h_cnt), 16'(bc.v_cnt)};

  function automatic int htot(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic obs_t rst_obs(cfg_t c);
    obs_t o;
    o    = '0;
    o.hs = ~c.pol;
    o.vs = ~c.pol;
    return o;
  endfunction

  // Output state after the n-th enabled clk since reset
  function automatic obs_t model(cfg_t c, longint n);
    obs_t   o;
    longint ht, vt, t, h, v;
    ht   = htot(c);
    vt   = vtot(c);
    t    = n / c.d;
    h    = t % ht;
    v    = (t / ht) % vt;
    o.h  = 16'(h);
    o.v  = 16'(v);
    o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs)
           ? c.pol : ~c.pol;
    o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs)
           ? c.pol : ~c.pol;
    o.dv = (h < c.ha) && (v < c.va);
    o.du = (n % c.d == 0) && (t % (ht * vt) == c.va * ht);
    return o;
  endfunction

  longint na = 0, nb = 0, nc = 0;
  obs_t   ea, eb, ec;

  always @(posedge clk) begin
    if (rst_a) begin
      na <= 0;
      ea <= rst_obs(CA);
    end else if (ba.en) begin
      na <= na + 1;
      ea <= model(CA, na + 1);
    end else begin
      ea.du <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      nb <= 0;
      eb <= rst_obs(CB);
    end else if (bb.en) begin
      nb <= nb + 1;
      eb <= model(CB, nb + 1);
    end else begin
      eb.du <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_c) begin
      nc <= 0;
      ec <= rst_obs(CC);
    end else if (bc.en) begin
      nc <= nc + 1;
      ec <= model(CC, nc + 1);
    end else begin
      ec.du <= 1'b0;
    end
  end

  task automatic test_reset();
    int k;
    rst_a  = 1'b1;
    ba.en  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (oa !== rst_obs(CA)) begin
        errors++;
        $display("FAIL reset_vals: got %h want %h", oa, rst_obs(CA));
      end
    end
    rst_a = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL first_tick_model: got %h want %h", oa, ea);
      end
    end while (oa.h == 0 && k < 20);
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d want 4", k);
    end
  endtask

  task automatic test_en_hold();
    obs_t held;
    int   k, en_clks;
    bit   en_prev;
    en_clks = 0;
    k = 0;
    while (!(oa.h == 100 && oa.v == 0) && k < 1000) begin
      en_prev = ba.en;
      @(negedge clk);
      k++;
      if (en_prev) en_clks++;
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL en_pre_model: got %h want %h", oa, ea);
      end
    end
    checks++;
    if (k >= 1000) begin
      errors++;
      $display("FAIL en_reach_h100: got h=%0d want 100", oa.h);
    end
    held    = oa;
    held.du = 1'b0;
    ba.en   = 1'b0;
    repeat (37) begin
      @(negedge clk);
      checks++;
      if (oa !== held || oa !== ea) begin
        errors++;
        $display("FAIL en_hold: got %h want %h", oa, held);
      end
    end
    ba.en = 1'b1;
    k = 0;
    while (!(oa.h == 1 && oa.v == 1) && k < 5000) begin
      en_prev = ba.en;
      @(negedge clk);
      k++;
      if (en_prev) en_clks++;
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL en_post_model: got %h want %h", oa, ea);
      end
    end
    checks++;
    if (en_clks !== htot(CA) * CA.d) begin
      errors++;
      $display("FAIL en_line_len: got %0d want %0d",
               en_clks, htot(CA) * CA.d);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (oa.h != 700 && k < 4000) begin
      @(negedge clk);
      k++;
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL mid_pre_model: got %h want %h", oa, ea);
      end
    end
    checks++;
    if (oa.hs !== CA.pol) begin
      errors++;
      $display("FAIL mid_in_hs: got hs=%0b h=%0d want hs=%0b h=700",
               oa.hs, oa.h, CA.pol);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if (oa !== rst_obs(CA)) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", oa, rst_obs(CA));
    end
    rst_a = 1'b0;
    repeat (60) begin
      @(negedge clk);
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL mid_restart: got %h want %h", oa, ea);
      end
    end
  endtask

  task automatic test_frame();
    int   ht, vt, fr;
    int   hs_p, hs_c, vs_c, dv_c, du_c, vw, bad_w;
    obs_t prev;
    ht = htot(CB);
    vt = vtot(CB);
    fr = ht * vt * CB.d;
    hs_p = 0; hs_c = 0; vs_c = 0; dv_c = 0;
    du_c = 0; vw = 0; bad_w = 0;
    rst_b = 1'b1;
    bb.en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ob !== rst_obs(CB)) begin
        errors++;
        $display("FAIL frame_reset: got %h want %h", ob, rst_obs(CB));
      end
    end
    rst_b = 1'b0;
    prev  = ob;
    for (int i = 1; i <= 2 * fr; i++) begin
      @(negedge clk);
      checks++;
      if (ob !== eb) begin
        errors++;
        $display("FAIL frame_model: got %h want %h", ob, eb);
      end
      if (i <= fr) begin
        if (ob.hs == CB.pol && prev.hs != CB.pol) hs_p++;
        if (ob.hs == CB.pol) hs_c++;
        if (ob.vs == CB.pol) vs_c++;
        if (ob.dv) dv_c++;
      end
      if (ob.du) du_c++;
      if (prev.v == 16'(vt - 1) && ob.v == 0) begin
        vw++;
        if (!(prev.h == 16'(ht - 1) && ob.h == 0)) bad_w++;
      end
      prev = ob;
    end
    checks++;
    if (hs_p !== vt) begin
      errors++;
      $display("FAIL frame_hs_pulses: got %0d want %0d", hs_p, vt);
    end
    checks++;
    if (hs_c !== vt * CB.hs * CB.d) begin
      errors++;
      $display("FAIL frame_hs_clks: got %0d want %0d",
               hs_c, vt * CB.hs * CB.d);
    end
    checks++;
    if (vs_c !== CB.vs * ht * CB.d) begin
      errors++;
      $display("FAIL frame_vs_clks: got %0d want %0d",
               vs_c, CB.vs * ht * CB.d);
    end
    checks++;
    if (dv_c !== CB.ha * CB.va * CB.d) begin
      errors++;
      $display("FAIL frame_dv_clks: got %0d want %0d",
               dv_c, CB.ha * CB.va * CB.d);
    end
    checks++;
    if (du_c !== 2) begin
      errors++;
      $display("FAIL frame_uart_pulses: got %0d want 2", du_c);
    end
    checks++;
    if (vw !== 2 || bad_w !== 0) begin
      errors++;
      $display("FAIL frame_v_wrap: got %0d wraps %0d bad want 2 0",
               vw, bad_w);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 600; i++) begin
      bb.en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (ob !== eb) begin
        errors++;
        $display("FAIL rand_en_model: got %h want %h", ob, eb);
      end
    end
    bb.en = 1'b1;
  endtask

  task automatic test_small();
    int   hw, vw, bad;
    obs_t prev;
    hw = 0; vw = 0; bad = 0;
    rst_c = 1'b1;
    bc.en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (oc !== rst_obs(CC)) begin
      errors++;
      $display("FAIL small_reset: got %h want %h", oc, rst_obs(CC));
    end
    rst_c = 1'b0;
    prev  = oc;
    for (int i = 1; i <= 2 * htot(CC) * vtot(CC) + 5; i++) begin
      @(negedge clk);
      checks++;
      if (oc !== ec) begin
        errors++;
        $display("FAIL small_model: got %h want %h", oc, ec);
      end
      if (oc.hs !== (oc.h == 9 || oc.h == 10)) bad++;
      if (prev.h == 11 && oc.h == 0) hw++;
      if (prev.v == 6 && oc.v == 0) begin
        vw++;
        if (prev.h != 11) bad++;
      end
      prev = oc;
    end
    checks++;
    if (bad !== 0 || hw !== 14 || vw !== 2) begin
      errors++;
      $display("FAIL small_wraps: got bad=%0d hw=%0d vw=%0d want 0 14 2",
               bad, hw, vw);
    end
  endtask

  initial begin
    ba.en = 1'b0;
    bb.en = 1'b0;
    bc.en = 1'b0;
    test_reset();
    test_en_hold();
    test_reset_mid();
    test_frame();
    test_random_en();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
